// File: rtl/decoder_stream_if.sv
// Command/beat handshake bundle for decoder_stream: index commands in, decoded words out.
// The master drives commands and accepts beats; the slave is the decoder.
interface decoder_stream_if #(
  parameter int OP_WIDTH = 4
);
  localparam int IP_SIZE = $clog2(OP_WIDTH);

  logic                en;
  logic                in_valid;
  logic                in_ready;
  logic [IP_SIZE-1:0]  a;
  logic                burst;
  logic                out_valid;
  logic                out_ready;
  logic [OP_WIDTH-1:0] op;
  logic                out_last;
  logic                err;

  modport master (
    output en, in_valid, a, burst, out_ready,
    input  in_ready, out_valid, op, out_last, err
  );

  modport slave (
    input  en, in_valid, a, burst, out_ready,
    output in_ready, out_valid, op, out_last, err
  );
endinterface

// File: rtl/decoder_stream.sv
// Streaming binary-to-one-hot/thermometer decoder with optional burst expansion
// of one command into a walking sequence of words up to the top line.
module decoder_stream #(
  parameter int OP_WIDTH    = 4,
  parameter int THERMOMETER = 0
) (
  input  logic             clk,
  input  logic             rst,
  decoder_stream_if.slave  io
);
  localparam int IP_SIZE = $clog2(OP_WIDTH);
  localparam logic [IP_SIZE-1:0] LAST_IDX = IP_SIZE'(OP_WIDTH - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              state_q, state_d;
  logic [IP_SIZE-1:0]  cur_idx_q, cur_idx_d;
  logic                en_q, en_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready;

  function automatic logic [OP_WIDTH-1:0] decode(input logic [IP_SIZE-1:0] idx,
                                                 input logic enable);
    logic [OP_WIDTH-1:0] w;
    w = '0;
    if (enable) begin
      for (int i = 0; i < OP_WIDTH; i++) begin
        if (THERMOMETER != 0) w[i] = (i <= int'(idx));
        else                  w[i] = (i == int'(idx));
      end
    end
    return w;
  endfunction

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || io.out_ready) && !rst;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a signal unassigned
    // (which would infer a latch) and idle cycles simply hold state.
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    en_d        = en_q;
    op_d        = op_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready) begin
          out_valid_d = 1'b1;
          en_d        = io.en;
          if (int'(io.a) >= OP_WIDTH) begin
            // Out-of-range index collapses to one flagged, empty beat, even in burst.
            op_d       = '0;
            err_d      = 1'b1;
            out_last_d = 1'b1;
          end else begin
            op_d  = decode(io.a, io.en);
            err_d = 1'b0;
            if (io.burst && (io.a < LAST_IDX)) begin
              cur_idx_d  = io.a + 1'b1;
              out_last_d = 1'b0;
              state_d    = SWEEP;
            end else begin
              out_last_d = 1'b1;
            end
          end
        end else if (out_valid_q && io.out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      SWEEP: begin
        if (io.out_ready) begin
          op_d  = decode(cur_idx_q, en_q);
          err_d = 1'b0;
          if (cur_idx_q == LAST_IDX) begin
            // Leave cur_idx parked so it never wraps past the top line.
            out_last_d = 1'b1;
            state_d    = IDLE;
          end else begin
            out_last_d = 1'b0;
            cur_idx_d  = cur_idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_idx_q   <= '0;
      en_q        <= 1'b0;
      op_q        <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      en_q        <= en_d;
      op_q        <= op_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    io.in_ready  = in_ready;
    io.out_valid = out_valid_q;
    io.op        = op_q;
    io.out_last  = out_last_q;
    io.err       = err_q;
  end
endmodule
